// File: rtl/prio_arbiter8_if.sv
// Bundle of request/grant signals shared between prio_arbiter8 and its requesters.
// Signal names keep the arbiter's point of view (i* driven toward it, o* driven by it).
interface prio_arbiter8_if;
  logic [7:0] iReq;      // active-low requests, bit 7 highest priority
  logic       iEI;       // active-low enable
  logic       iDone;     // owner releases the resource
  logic [7:0] oGrant;    // one-hot active-low grant
  logic [2:0] oGrantId;  // inverted owner index
  logic       oValid;    // a grant is held
  logic       oEO;       // active-low "enabled but idle"
  logic       oTimeout;  // pulse on forced release

  // Requester side drives requests and observes grants
  modport master (
    output iReq, iEI, iDone,
    input  oGrant, oGrantId, oValid, oEO, oTimeout
  );

  // Arbiter side
  modport slave (
    input  iReq, iEI, iDone,
    output oGrant, oGrantId, oValid, oEO, oTimeout
  );
endinterface

// File: rtl/prio_arbiter8.sv
// prio_arbiter8: 8-requester arbiter with registered grant holding, end-of-use
// handshake, hold-time limit and a one-cycle dead gap between owners.
// Optional macro ARB_ROUND_ROBIN_EN: rotate the search start past the last owner
// instead of fixed priority (bit 7 highest).
module prio_arbiter8 #(
  parameter int HOLD_MAX = 15,  // forced release after this many grant cycles; 0 = no limit
  parameter int CNT_W    = 4    // hold counter width, 2**CNT_W > HOLD_MAX
) (
  input logic           iClk,
  input logic           iRst,
  prio_arbiter8_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} stateT;

  stateT            stateReg, stateNext;
  logic [2:0]       winnerReg, winnerNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [7:0]       grantReg, grantNext;
  logic [2:0]       grantIdReg, grantIdNext;
  logic             validReg, validNext;
  logic             timeoutReg, timeoutNext;

  logic [2:0] searchStart;  // highest-priority index for this arbitration
  logic [2:0] scanIdx;
  logic [2:0] pick;         // winner among current requests
  logic       anyReq;
  logic       holdHit;      // counter has reached the last allowed grant cycle
  logic       endGrant;     // current grant ends at this edge
  logic       timeoutOnly;  // hold limit is the only reason to end

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] ptrReg;

  // Rotate pointer: next search starts just below the owner whose grant ended
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ptrReg <= 3'd7;
    end else if (stateReg == GRANT && endGrant) begin
      ptrReg <= winnerReg - 3'd1;
    end
  end

  assign searchStart = ptrReg;
`else
  assign searchStart = 3'd7;
`endif

  // Priority search downward from searchStart with wrap; the nearest active request wins
  always_comb begin
    anyReq  = ~&bus.iReq;
    pick    = 3'd0;
    scanIdx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      scanIdx = searchStart - 3'(k);
      if (!bus.iReq[scanIdx]) pick = scanIdx;
    end
  end

  generate
    if (HOLD_MAX != 0) begin : gHoldLimit
      assign holdHit = (cntReg == CNT_W'(HOLD_MAX - 1));
    end else begin : gNoHoldLimit
      assign holdHit = 1'b0;
    end
  endgenerate

  assign endGrant    = bus.iDone | bus.iReq[winnerReg] | bus.iEI | holdHit;
  assign timeoutOnly = holdHit & ~bus.iDone & ~bus.iReq[winnerReg] & ~bus.iEI;

  // State and registered outputs; reset drops any grant on the same edge
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg   <= IDLE;
      winnerReg  <= 3'd0;
      cntReg     <= '0;
      grantReg   <= 8'hFF;
      grantIdReg <= 3'b111;
      validReg   <= 1'b0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      winnerReg  <= winnerNext;
      cntReg     <= cntNext;
      grantReg   <= grantNext;
      grantIdReg <= grantIdNext;
      validReg   <= validNext;
      timeoutReg <= timeoutNext;
    end
  end

  // Next-state: arbitrate in IDLE, hold until a release cause, one dead GAP cycle
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (!bus.iEI && anyReq) stateNext = GRANT;
      GRANT:   if (endGrant) stateNext = GAP;
      GAP:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Next registered outputs: grant appears on the arbitration edge, clears on release
  always_comb begin
    winnerNext  = winnerReg;
    cntNext     = cntReg;
    grantNext   = 8'hFF;
    grantIdNext = 3'b111;
    validNext   = 1'b0;
    timeoutNext = 1'b0;
    case (stateReg)
      IDLE: begin
        if (!bus.iEI && anyReq) begin
          winnerNext  = pick;
          cntNext     = '0;
          grantNext   = ~(8'b1 << pick);
          grantIdNext = ~pick;
          validNext   = 1'b1;
        end
      end
      GRANT: begin
        cntNext = (&cntReg) ? cntReg : cntReg + 1'b1;
        if (endGrant) begin
          timeoutNext = timeoutOnly;
        end else begin
          grantNext   = grantReg;
          grantIdNext = grantIdReg;
          validNext   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.oGrant   = grantReg;
  assign bus.oGrantId = grantIdReg;
  assign bus.oValid   = validReg;
  assign bus.oTimeout = timeoutReg;
  assign bus.oEO      = ~(~bus.iEI && stateReg == IDLE && &bus.iReq);

endmodule

// File: tb/tb_prio_arbiter8.sv
// Testbench for prio_arbiter8: directed scenarios plus random traffic, every cycle
// compared against a behavioural owner/gap model. Honours ARB_ROUND_ROBIN_EN.
module tb_prio_arbiter8;
  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = 4;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  always #5 iClk = ~iClk;

  prio_arbiter8_if arbIf ();

  prio_arbiter8 #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (arbIf)
  );

  int totalCnt = 0;
  int badCnt   = 0;

  // Model: who owns the resource (-1 none), whether a dead cycle is pending,
  // how many cycles the owner has held, and the round-robin start point.
  int mOwner;
  bit mInGap;
  int mHeld;
  int mPtr;
  bit mTimeout;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pickOwner(input logic [7:0] req, input int start);
    for (int k = 0; k < 8; k++) begin
      int idx = (start - k + 8) % 8;
      if (req[idx] == 1'b0) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mOwner = -1; mInGap = 0; mHeld = 0; mPtr = 7; mTimeout = 0;
  endtask

  task automatic modelEdge(input logic [7:0] req, input logic ei, input logic done, input logic rst);
    bit limit;
    if (rst) begin
      modelReset();
      return;
    end
    mTimeout = 0;
    if (mOwner >= 0) begin
      limit = (HOLD_MAX != 0) && (mHeld == HOLD_MAX);
      if (done || req[mOwner] || ei || limit) begin
        mTimeout = limit && !done && !req[mOwner] && !ei;
`ifdef ARB_ROUND_ROBIN_EN
        mPtr = (mOwner + 7) % 8;
`endif
        mOwner = -1;
        mInGap = 1;
      end else begin
        mHeld++;
      end
    end else if (mInGap) begin
      mInGap = 0;
    end else if (!ei && req != 8'hFF) begin
      mOwner = pickOwner(req, mPtr);
      mHeld  = 1;
    end
  endtask

  task automatic checkOutputs();
    logic [7:0] expGrant;
    logic [2:0] expId;
    expGrant = (mOwner < 0) ? 8'hFF : ~(8'h01 << mOwner);
    expId    = (mOwner < 0) ? 3'd7 : 3'(7 - mOwner);
    checkVal("grant",   32'(arbIf.oGrant),   32'(expGrant));
    checkVal("grantId", 32'(arbIf.oGrantId), 32'(expId));
    checkVal("valid",   32'(arbIf.oValid),   32'(mOwner >= 0));
    checkVal("timeout", 32'(arbIf.oTimeout), 32'(mTimeout));
  endtask

  // One cycle: drive inputs, check combinational oEO, clock, update model, check registers
  task automatic step(input logic [7:0] req, input logic ei, input logic done, input logic rst);
    bit idle;
    arbIf.iReq  = req;
    arbIf.iEI   = ei;
    arbIf.iDone = done;
    iRst        = rst;
    #1;
    idle = (mOwner < 0) && !mInGap;
    checkVal("eo", 32'(arbIf.oEO), 32'(!(!ei && idle && req == 8'hFF)));
    @(posedge iClk);
    modelEdge(req, ei, done, rst);
    #1;
    checkOutputs();
    $display("cyc t=%0t req=%b ei=%b done=%b rst=%b -> grant=%b id=%0d v=%b to=%b",
             $time, req, ei, done, rst, arbIf.oGrant, arbIf.oGrantId, arbIf.oValid, arbIf.oTimeout);
  endtask

  initial begin
    logic [7:0] rq;
    int expOwner;
    arbIf.iReq = 8'hFF; arbIf.iEI = 1'b0; arbIf.iDone = 1'b0;
    modelReset();

    // Reset and idle
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0, 1'b0);
    checkVal("eoIdle", 32'(arbIf.oEO), 32'd0);
    step(8'hFF, 1'b1, 1'b0, 1'b0);
    checkVal("eoDisabled", 32'(arbIf.oEO), 32'd1);

    // Fixed priority grant, then forced release after HOLD_MAX cycles
    step(8'b0101_1110, 1'b0, 1'b0, 1'b0);
    checkVal("prio7Grant", 32'(arbIf.oGrant), 32'h7F);
    checkVal("prio7Id", 32'(arbIf.oGrantId), 32'd0);
    for (int i = 0; i < HOLD_MAX; i++) step(8'b0101_1110, 1'b0, 1'b0, 1'b0);
    checkVal("holdTimeout", 32'(arbIf.oTimeout), 32'd1);
    step(8'b1101_1110, 1'b0, 1'b0, 1'b0);  // GAP
    checkVal("gapNoGrant", 32'(arbIf.oValid), 32'd0);
    step(8'b1101_1110, 1'b0, 1'b0, 1'b0);
    checkVal("grant5Id", 32'(arbIf.oGrantId), 32'b010);
    step(8'hFF, 1'b0, 1'b0, 1'b0);         // withdraw
    step(8'hFF, 1'b0, 1'b0, 1'b0);         // GAP

    // Release paths for owner 3: done, withdraw, disable
    for (int path = 0; path < 3; path++) begin
      step(8'b1111_0111, 1'b0, 1'b0, 1'b0);
      step(8'b1111_0111, 1'b0, 1'b0, 1'b0);
      step(8'b1111_0111, 1'b0, 1'b0, 1'b0);
      step((path == 1) ? 8'hFF : 8'b1111_0111, (path == 2), (path == 0), 1'b0);
      checkVal("releaseDrop", 32'(arbIf.oGrant), 32'hFF);
      step(8'hFF, 1'b0, 1'b0, 1'b0);
    end

    // No preemption by a higher request
    step(8'b1111_1011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(8'b0111_1011, 1'b0, 1'b0, 1'b0);
    checkVal("noPreempt", 32'(arbIf.oGrant), 32'hFB);
    step(8'b0111_1011, 1'b0, 1'b1, 1'b0);
    step(8'b0111_1011, 1'b0, 1'b0, 1'b0);
    step(8'b0111_1011, 1'b0, 1'b0, 1'b0);
    checkVal("afterPreempt7", 32'(arbIf.oGrantId), 32'd0);
    step(8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a grant
    step(8'b1011_1111, 1'b0, 1'b0, 1'b0);
    step(8'b1011_1111, 1'b0, 1'b0, 1'b1);
    checkVal("rstMidGrant", 32'(arbIf.oGrant), 32'hFF);

    // All requesting, done pulsed each grant: rotation or fixed 7
    for (int i = 0; i < 9; i++) begin
      step(8'h00, 1'b0, 1'b0, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
      expOwner = (7 - i + 16) % 8;
`else
      expOwner = 7;
`endif
      checkVal("rrOrder", 32'(arbIf.oGrantId), 32'(7 - expOwner));
      step(8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rq = 8'hFF;
        1:       rq = ~(8'h01 << $urandom_range(0, 7));
        default: rq = 8'($urandom);
      endcase
      step(rq, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end
endmodule
